// File: rtl/ins_dispatch_pkg.sv
// Shared constants for the instruction dispatcher: opcodes, MSB-relative
// field offsets (add O = INST_W-64), FSM states and the layer config record.
package ins_dispatch_pkg;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_CALC = 2'b01,
        OP_SAVE = 2'b10,
        OP_CONF = 2'b11
    } op_e;

    localparam int F_OP_HI  = 63;
    localparam int F_OP_LO  = 62;
    localparam int F_LT_HI  = 61;
    localparam int F_LT_LO  = 58;
    localparam int F_BIAS   = 58;
    localparam int F_POOL   = 57;
    localparam int F_RELU   = 56;
    localparam int F_ID_HI  = 57;
    localparam int F_ID_LO  = 52;
    localparam int F_ICH_HI = 55;
    localparam int F_ICH_LO = 52;
    localparam int F_OCH_HI = 51;
    localparam int F_OCH_LO = 48;
    localparam int F_IW_HI  = 47;
    localparam int F_IW_LO  = 40;
    localparam int F_OW_HI  = 39;
    localparam int F_OW_LO  = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_WAIT,
        S_ISSUE,
        S_CONF
    } state_e;

    typedef struct packed {
        logic [3:0] layer_type;
        logic [3:0] in_ch_seg;
        logic [3:0] out_ch_seg;
        logic [7:0] in_img_width;
        logic [7:0] out_img_width;
        logic       pooling;
        logic       relu;
        logic       depool;
    } conf_t;

endpackage

// File: rtl/ins_dispatch_if.sv
// Valid/ready instruction channel; master drives valid+data, slave drives ready.
interface ins_dispatch_if #(
    parameter int W = 64
) ();
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/ins_dispatch_pe_group_mask.sv
// Combinational PE target mask: single PE or a GROUP-wide aligned block,
// flagged illegal when the block runs past PE_NUM.
module pe_group_mask #(
    parameter int PE_NUM = 32,
    parameter int GROUP  = 4
) (
    input  logic [5:0]        id_i,
    input  logic              single_i,
    output logic [PE_NUM-1:0] mask_o,
    output logic              illegal_o
);
    localparam int SW = 16;

    logic [SW-1:0] first;
    logic [SW-1:0] span;
    logic [SW-1:0] last_x;

    always_comb begin
        first     = single_i ? SW'(id_i) : SW'(id_i) * SW'(GROUP);
        span      = single_i ? SW'(1) : SW'(GROUP);
        last_x    = first + span;
        illegal_o = last_x > SW'(PE_NUM);
    end

    for (genvar p = 0; p < PE_NUM; p++) begin : g_bit
        assign mask_o[p] = (SW'(p) >= first) && (SW'(p) < last_x);
    end

endmodule

// File: rtl/ins_dispatch.sv
// Layer instruction dispatcher: accepts one instruction, waits on its
// dependencies, then issues it on a channel or applies it as layer config.
module ins_dispatch
    import ins_dispatch_pkg::*;
#(
    parameter int PE_NUM   = 32,
    parameter int GROUP    = 4,
    parameter int INST_W   = 64,
    parameter int WAIT_MAX = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    ins_dispatch_if.slave     ins_s,
    ins_dispatch_if.master    ddr2pe_m,
    ins_dispatch_if.master    pe_m,
    ins_dispatch_if.master    pe2ddr_m,
    input  logic              ddr2pe_busy_i,
    input  logic              pe2ddr_busy_i,
    input  logic [PE_NUM-1:0] pe_done_i,
    output logic [3:0]        conf_layer_type_o,
    output logic [3:0]        conf_in_ch_seg_o,
    output logic [3:0]        conf_out_ch_seg_o,
    output logic [7:0]        conf_in_img_width_o,
    output logic [7:0]        conf_out_img_width_o,
    output logic              conf_pooling_o,
    output logic              conf_relu_o,
    output logic              conf_depool_o,
    output logic [PE_NUM-1:0] switch_d_o,
    output logic [PE_NUM-1:0] switch_p_o,
    output logic [PE_NUM-1:0] switch_i_o,
    output logic [PE_NUM-1:0] switch_a_o,
    output logic              switch_b_o,
    output logic              working_o,
    output logic              err_illegal_o,
    output logic              err_timeout_o
);
    localparam int O  = INST_W - 64;
    localparam int CW = $clog2(WAIT_MAX + 1);

    state_e              state_q, state_d;
    logic [INST_W-1:0]   ins_q;
    op_e                 op_q;
    logic [PE_NUM-1:0]   mask_q, mask_c;
    logic                illegal_q, illegal_c;
    conf_t               conf_q;
    logic                all_done_q;
    logic [CW-1:0]       cnt_q;
    logic                err_to_q;
    logic [PE_NUM-1:0]   sw_d_q, sw_a_q;
    logic                sw_b_q;

    logic accept, chan_ready, hs, deps_met, alt_a;
    logic ins_ready, v_ddr2pe, v_pe, v_pe2ddr, err_ill;

    // Mask uses the config in force at accept time; no back-to-back accept
    // means a pending conf has always landed by then.
    pe_group_mask #(
        .PE_NUM (PE_NUM),
        .GROUP  (GROUP)
    ) u_mask (
        .id_i      (ins_s.data[O+F_ID_HI:O+F_ID_LO]),
        .single_i  (conf_q.layer_type[0]),
        .mask_o    (mask_c),
        .illegal_o (illegal_c)
    );

    assign accept = ins_s.valid && ins_ready;
    assign alt_a  = conf_q.layer_type[2:1] == 2'b10;

    always_comb begin
        chan_ready = 1'b0;
        unique case (op_q)
            OP_LOAD: chan_ready = ddr2pe_m.ready;
            OP_CALC: chan_ready = pe_m.ready;
            OP_SAVE: chan_ready = pe2ddr_m.ready;
            default: chan_ready = 1'b0;
        endcase
    end

    assign hs = (state_q == S_ISSUE) && chan_ready;

    always_comb begin
        deps_met = 1'b0;
        unique case (op_q)
            OP_LOAD: deps_met = 1'b1;
            OP_CALC,
            OP_SAVE: deps_met = (pe_done_i & mask_q) == mask_q;
            default: deps_met = all_done_q;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (accept) state_d = S_CHECK;
            S_CHECK: state_d = illegal_q ? S_IDLE : S_WAIT;
            S_WAIT:  if (deps_met) state_d = (op_q == OP_CONF) ? S_CONF : S_ISSUE;
            S_ISSUE: if (chan_ready) state_d = S_IDLE;
            S_CONF:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        ins_ready = state_q == S_IDLE;
        v_ddr2pe  = (state_q == S_ISSUE) && (op_q == OP_LOAD);
        v_pe      = (state_q == S_ISSUE) && (op_q == OP_CALC);
        v_pe2ddr  = (state_q == S_ISSUE) && (op_q == OP_SAVE);
        err_ill   = (state_q == S_CHECK) && illegal_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ins_q      <= '0;
            op_q       <= OP_LOAD;
            mask_q     <= '0;
            illegal_q  <= 1'b0;
            conf_q     <= '0;
            all_done_q <= 1'b0;
            cnt_q      <= '0;
            err_to_q   <= 1'b0;
            sw_d_q     <= '0;
            sw_a_q     <= '0;
            sw_b_q     <= 1'b0;
        end else begin
            all_done_q <= !ddr2pe_busy_i && !pe2ddr_busy_i && (&pe_done_i);
            if (accept) begin
                ins_q     <= ins_s.data;
                op_q      <= op_e'(ins_s.data[O+F_OP_HI:O+F_OP_LO]);
                mask_q    <= mask_c;
                illegal_q <= illegal_c && (op_e'(ins_s.data[O+F_OP_HI:O+F_OP_LO]) != OP_CONF);
            end
            if (state_q == S_CONF) begin
                conf_q.layer_type    <= ins_q[O+F_LT_HI:O+F_LT_LO];
                conf_q.in_ch_seg     <= ins_q[O+F_ICH_HI:O+F_ICH_LO];
                conf_q.out_ch_seg    <= ins_q[O+F_OCH_HI:O+F_OCH_LO];
                conf_q.in_img_width  <= ins_q[O+F_IW_HI:O+F_IW_LO];
                conf_q.out_img_width <= ins_q[O+F_OW_HI:O+F_OW_LO];
                if (ins_q[O+F_LT_HI:O+F_LT_HI-1] == 2'b00) begin
                    conf_q.pooling <= ins_q[O+F_POOL];
                    conf_q.relu    <= ins_q[O+F_RELU];
                    conf_q.depool  <= 1'b0;
                end else begin
                    conf_q.pooling <= 1'b0;
                    conf_q.relu    <= 1'b0;
                    conf_q.depool  <= ins_q[O+F_POOL];
                end
            end
            // Stall counter saturates; timeout only flags, never aborts
            if (state_q == S_WAIT || state_q == S_ISSUE) begin
                if (cnt_q != CW'(WAIT_MAX)) cnt_q <= cnt_q + 1'b1;
            end else begin
                cnt_q <= '0;
            end
            if (cnt_q == CW'(WAIT_MAX)) err_to_q <= 1'b1;
            sw_d_q <= (hs && op_q == OP_CALC) ? mask_q : '0;
            sw_a_q <= (hs && (op_q == OP_SAVE || (op_q == OP_CALC && alt_a))) ? mask_q : '0;
            sw_b_q <= hs && (op_q == OP_SAVE) && alt_a && ins_q[O+F_BIAS];
        end
    end

    assign ins_s.ready    = ins_ready;
    assign ddr2pe_m.valid = v_ddr2pe;
    assign pe_m.valid     = v_pe;
    assign pe2ddr_m.valid = v_pe2ddr;
    assign ddr2pe_m.data  = ins_q;
    assign pe_m.data      = ins_q;
    assign pe2ddr_m.data  = ins_q;

    assign conf_layer_type_o    = conf_q.layer_type;
    assign conf_in_ch_seg_o     = conf_q.in_ch_seg;
    assign conf_out_ch_seg_o    = conf_q.out_ch_seg;
    assign conf_in_img_width_o  = conf_q.in_img_width;
    assign conf_out_img_width_o = conf_q.out_img_width;
    assign conf_pooling_o       = conf_q.pooling;
    assign conf_relu_o          = conf_q.relu;
    assign conf_depool_o        = conf_q.depool;

    assign switch_d_o    = sw_d_q;
    assign switch_p_o    = sw_d_q;
    assign switch_i_o    = sw_d_q;
    assign switch_a_o    = sw_a_q;
    assign switch_b_o    = sw_b_q;
    assign working_o     = (state_q != S_IDLE) || ins_s.valid || !all_done_q;
    assign err_illegal_o = err_ill;
    assign err_timeout_o = err_to_q;

endmodule
